// File: rtl/rv32_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv32_mem_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - RV32 funct3 encodings for loads (F3_LB..F3_LHU) and stores (F3_SB..F3_SW)
//   - FSM state encoding of the access sequencer (IDLE -> ACCESS -> DONE)
//   - default memory-acknowledge timeout
//   - access-size decode helper shared by the fault and lane logic
// No ports (package).
// -----------------------------------------------------------------------------
package rv32_mem_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access sequencer states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Cycles allowed in ACCESS without MEM_ACK
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_e;

   // funct3[1:0] carries the access size for both loads and stores; the
   // unsigned-ness bit funct3[2] does not change it. Encoding 11 is illegal
   // and is rejected by the funct3 legality check, so its size is irrelevant.
   function automatic access_size_e f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b01:   f3_size = SZ_HALF;
         2'b10:   f3_size = SZ_WORD;
         default: f3_size = SZ_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the load/store unit (master) and the data
// memory / cache (slave).
//   MEM_READ       master->slave  read strobe, held for the whole access
//   MEM_WRITE      master->slave  write strobe, held for the whole access
//   MEM_ADDRESS    master->slave  word-aligned byte address
//   MEM_WRITEDATA  master->slave  lane-replicated store data
//   MEM_BYTE_EN    master->slave  byte lane enables
//   MEM_READDATA   slave->master  read word, valid in the MEM_ACK cycle
//   MEM_ACK        slave->master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface mem_access_unit_if;

   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [31:0] MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [3:0]  MEM_BYTE_EN;
   logic [31:0] MEM_READDATA;
   logic        MEM_ACK;

   modport master (
      output MEM_READ,
      output MEM_WRITE,
      output MEM_ADDRESS,
      output MEM_WRITEDATA,
      output MEM_BYTE_EN,
      input  MEM_READDATA,
      input  MEM_ACK
   );

   modport slave (
      input  MEM_READ,
      input  MEM_WRITE,
      input  MEM_ADDRESS,
      input  MEM_WRITEDATA,
      input  MEM_BYTE_EN,
      output MEM_READDATA,
      output MEM_ACK
   );

endinterface

// File: rtl/mem_load_formatter.sv
// -----------------------------------------------------------------------------
// mem_load_formatter
// Combinational load-data alignment and extension.
//   rdata   in  32  word returned by memory
//   funct3  in  3   load type (LB, LH, LW, LBU, LHU)
//   offset  in  2   byte offset of the load address inside the word
//   data    out 32  selected byte/half/word, sign- or zero-extended
// -----------------------------------------------------------------------------
module mem_load_formatter
   import rv32_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      // Halfwords are always aligned, so only offset[1] picks the half.
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      data     = rdata;
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         F3_LW:   data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit. Converts EX/MEM load/store requests into
// word-aligned, byte-enabled data-memory transactions, stalls the pipeline
// while a transaction is open and returns formatted load data.
//   CLK            in   clock
//   RESET          in   synchronous, active-high
//   IN_READ        in   load request
//   IN_WRITE       in   store request
//   IN_FUNC3       in   RV32 funct3 of the access
//   IN_ADDRESS     in   byte address
//   IN_WRITE_DATA  in   store data (rs2)
//   OUT_DMEM_OUT   out  formatted load data (registered)
//   OUT_BUSYWAIT   out  pipeline stall (combinational)
//   OUT_FAULT      out  bad request (combinational) or timeout (registered)
//   mem            --   data-memory bus, master side
// Parameter TIMEOUT_CYCLES: cycles spent in ACCESS without MEM_ACK before
// the access is abandoned and a fault is raised.
// -----------------------------------------------------------------------------
module mem_access_unit
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                IN_READ,
   input  logic                IN_WRITE,
   input  logic [2:0]          IN_FUNC3,
   input  logic [31:0]         IN_ADDRESS,
   input  logic [31:0]         IN_WRITE_DATA,
   output logic [31:0]         OUT_DMEM_OUT,
   output logic                OUT_BUSYWAIT,
   output logic                OUT_FAULT,
   mem_access_unit_if.master   mem
);

   localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_flag;
   logic [2:0]       acc_f3;
   logic [1:0]       acc_off;

   logic             req;
   logic             bad;
   logic             misalign;
   logic             load_f3_ok;
   logic             store_f3_ok;
   logic             start;
   access_size_e     size;
   logic [31:0]      load_fmt;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_SB:   store_be = 4'b0001 << off;
         F3_SH:   store_be = 4'b0011 << off;
         F3_SW:   store_be = 4'b1111;
         default: store_be = 4'b1111;
      endcase
   endfunction

   // Replicate the store operand across all lanes so the byte enables alone
   // decide which bytes land in memory.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         F3_SB:   store_data = {4{wd[7:0]}};
         F3_SH:   store_data = {2{wd[15:0]}};
         F3_SW:   store_data = wd;
         default: store_data = wd;
      endcase
   endfunction

   // Request decode and fault detection
   always_comb begin
      req         = IN_READ ^ IN_WRITE;
      size        = f3_size(IN_FUNC3);
      load_f3_ok  = (IN_FUNC3 == F3_LB)  || (IN_FUNC3 == F3_LH) || (IN_FUNC3 == F3_LW) ||
                    (IN_FUNC3 == F3_LBU) || (IN_FUNC3 == F3_LHU);
      store_f3_ok = (IN_FUNC3 == F3_SB)  || (IN_FUNC3 == F3_SH) || (IN_FUNC3 == F3_SW);
      misalign    = ((size == SZ_HALF) && IN_ADDRESS[0]) ||
                    ((size == SZ_WORD) && (IN_ADDRESS[1:0] != 2'b00));
      bad         = (IN_READ & IN_WRITE) |
                    (IN_READ  & ~IN_WRITE & (~load_f3_ok  | misalign)) |
                    (IN_WRITE & ~IN_READ  & (~store_f3_ok | misalign));
      start       = (state == ST_IDLE) & req & ~bad;
   end

   // The stall rises in the same cycle the request is seen so the pipeline
   // never advances past an access that has not been issued yet.
   assign OUT_BUSYWAIT = start | (state == ST_ACCESS);
   assign OUT_FAULT    = bad | tmo_flag;

   // Formatting uses the funct3/offset captured at issue, not the live inputs.
   mem_load_formatter u_fmt (
      .rdata  (mem.MEM_READDATA),
      .funct3 (acc_f3),
      .offset (acc_off),
      .data   (load_fmt)
   );

   // Access sequencer, timeout counter and registered bus outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= ST_IDLE;
         tmo_cnt           <= '0;
         tmo_flag          <= 1'b0;
         acc_f3            <= 3'd0;
         acc_off           <= 2'd0;
         OUT_DMEM_OUT      <= 32'd0;
         mem.MEM_READ      <= 1'b0;
         mem.MEM_WRITE     <= 1'b0;
         mem.MEM_ADDRESS   <= 32'd0;
         mem.MEM_WRITEDATA <= 32'd0;
         mem.MEM_BYTE_EN   <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state           <= ST_ACCESS;
                  tmo_cnt         <= '0;
                  acc_f3          <= IN_FUNC3;
                  acc_off         <= IN_ADDRESS[1:0];
                  mem.MEM_READ    <= IN_READ;
                  mem.MEM_WRITE   <= IN_WRITE;
                  mem.MEM_ADDRESS <= {IN_ADDRESS[31:2], 2'b00};
                  mem.MEM_BYTE_EN <= IN_READ ? 4'b1111 : store_be(IN_FUNC3, IN_ADDRESS[1:0]);
                  if (IN_WRITE) begin
                     mem.MEM_WRITEDATA <= store_data(IN_FUNC3, IN_WRITE_DATA);
                  end
               end
            end
            ST_ACCESS: begin
               // An acknowledge in the last allowed cycle still wins over the timeout.
               if (mem.MEM_ACK) begin
                  state         <= ST_DONE;
                  mem.MEM_READ  <= 1'b0;
                  mem.MEM_WRITE <= 1'b0;
                  if (mem.MEM_READ) begin
                     OUT_DMEM_OUT <= load_fmt;
                  end
               end else if (tmo_cnt == CNT_LAST) begin
                  state         <= ST_DONE;
                  mem.MEM_READ  <= 1'b0;
                  mem.MEM_WRITE <= 1'b0;
                  OUT_DMEM_OUT  <= 32'd0;
                  tmo_flag      <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // Pipeline advances on this edge; the old request is not re-issued.
               state    <= ST_IDLE;
               tmo_flag <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
